// File: rtl/jump_ctrl.sv
// rtl/jump_ctrl.sv - button conditioner and jump-charge controller
// Sync + debounce raw buttons, walk direction, and hold-time to launch-power conversion.
module jump_ctrl #(
   parameter int DEBOUNCE_CYC   = 4,
   parameter int TICK_DIV       = 10,
   parameter int CHARGE_TICKS   = 2,
   parameter int MAX_POWER      = 15,
   parameter int LAUNCH_TIMEOUT = 4
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       left_btn,
   input  logic       right_btn,
   input  logic       jump_btn,
   input  logic       on_ground,
   output logic [1:0] move_dir,
   output logic       jump_req,
   output logic [3:0] jump_power,
   output logic [1:0] jump_dir,
   output logic       charging
);

   localparam int DW = $clog2(DEBOUNCE_CYC + 1);
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW = (CHARGE_TICKS > 1) ? $clog2(CHARGE_TICKS) : 1;
   localparam int OW = (LAUNCH_TIMEOUT > 1) ? $clog2(LAUNCH_TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, CHARGE, RELEASE, AIR} state_t;

   // bit 0 = left, bit 1 = right, bit 2 = jump
   logic [2:0]    raw;
   logic [2:0]    sync1;
   logic [2:0]    sync2;
   logic [2:0]    db;
   logic [DW-1:0] db_cnt [3];

   assign raw = {jump_btn, right_btn, left_btn};

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
         db    <= '0;
         for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         for (int i = 0; i < 3; i++) begin
            if (sync2[i] == db[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DW'(DEBOUNCE_CYC - 1)) begin
               db[i]     <= ~db[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DW'(1);
            end
         end
      end
   end

   logic [1:0] dec;
   assign dec = (db[0] && !db[1]) ? 2'b10 :
                (db[1] && !db[0]) ? 2'b01 : 2'b00;

   state_t        state, state_n;
   logic          jmp_prev;
   logic          rise, fall;
   logic [TW-1:0] tick_cnt;
   logic          tick, tick_clr;
   logic [SW-1:0] step, step_n;
   logic [OW-1:0] to_cnt, to_n;
   logic          seen_low, seen_n;
   logic [3:0]    power_n;
   logic [1:0]    dir_n, move_n;

   assign rise     = db[2] && !jmp_prev;
   assign fall     = !db[2] && jmp_prev;
   assign tick     = (tick_cnt == TW'(TICK_DIV - 1));
   assign jump_req = (state == RELEASE);
   assign charging = (state == CHARGE);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state      <= IDLE;
         jmp_prev   <= 1'b0;
         tick_cnt   <= '0;
         step       <= '0;
         to_cnt     <= '0;
         seen_low   <= 1'b0;
         jump_power <= 4'd0;
         jump_dir   <= 2'b00;
         move_dir   <= 2'b00;
      end else begin
         state      <= state_n;
         jmp_prev   <= db[2];
         tick_cnt   <= (tick_clr || tick) ? '0 : tick_cnt + TW'(1);
         step       <= step_n;
         to_cnt     <= to_n;
         seen_low   <= seen_n;
         jump_power <= power_n;
         jump_dir   <= dir_n;
         move_dir   <= move_n;
      end
   end

   always_comb begin
      state_n  = state;
      step_n   = step;
      to_n     = to_cnt;
      seen_n   = seen_low;
      power_n  = jump_power;
      dir_n    = jump_dir;
      move_n   = 2'b00;
      tick_clr = 1'b0;
      case (state)
         IDLE: begin
            move_n = on_ground ? dec : 2'b00;
            if (rise && on_ground) begin
               state_n  = CHARGE;
               power_n  = 4'd1;
               step_n   = '0;
               dir_n    = dec;
               tick_clr = 1'b1;
            end
         end
         CHARGE: begin
            dir_n = dec;
            if (tick) begin
               if (step == SW'(CHARGE_TICKS - 1)) begin
                  step_n = '0;
                  if (jump_power < 4'(MAX_POWER)) power_n = jump_power + 4'd1;
               end else begin
                  step_n = step + SW'(1);
               end
            end
            // losing the ground cancels the charge even if the button falls in the same cycle
            if (!on_ground) begin
               state_n = IDLE;
               power_n = 4'd0;
               dir_n   = 2'b00;
            end else if (fall) begin
               state_n = RELEASE;
            end
         end
         RELEASE: begin
            state_n = AIR;
            to_n    = '0;
            seen_n  = 1'b0;
         end
         AIR: begin
            if (seen_low) begin
               if (on_ground) state_n = IDLE;
            end else if (!on_ground) begin
               seen_n = 1'b1;
            end else if (tick) begin
               if (to_cnt == OW'(LAUNCH_TIMEOUT - 1)) state_n = IDLE;
               else to_n = to_cnt + OW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_jump_ctrl.sv
// tb/tb_jump_ctrl.sv - directed vector bench for jump_ctrl
// Table of walk/decode vectors, then hand sequences for charge, abort, air and reset.
module tb_jump_ctrl;

   logic       sys_clk = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic       left_btn = 1'b0;
   logic       right_btn = 1'b0;
   logic       jump_btn = 1'b0;
   logic       on_ground = 1'b1;
   logic [1:0] move_dir;
   logic       jump_req;
   logic [3:0] jump_power;
   logic [1:0] jump_dir;
   logic       charging;

   jump_ctrl dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .left_btn   (left_btn),
      .right_btn  (right_btn),
      .jump_btn   (jump_btn),
      .on_ground  (on_ground),
      .move_dir   (move_dir),
      .jump_req   (jump_req),
      .jump_power (jump_power),
      .jump_dir   (jump_dir),
      .charging   (charging)
   );

   always #5 sys_clk = ~sys_clk;

   // {move_dir, charging, jump_req, jump_power, jump_dir}
   logic [9:0] obs;
   assign obs = {move_dir, charging, jump_req, jump_power, jump_dir};

   typedef struct {
      logic       l;
      logic       r;
      logic       g;
      int         cyc;
      logic [9:0] exp;
      string      name;
   } vec_t;

   vec_t tbl [11];
   int   tests = 0;
   int   fails = 0;

   task automatic cyc(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   initial begin
      int n;
      int pulses;
      int req_at;
      int move_at;
      int bad;
      logic [3:0] pw;
      logic [1:0] dr;

      tbl[0]  = '{1'b0, 1'b0, 1'b1, 2, 10'b00_0_0_0000_00, "reset_idle"};
      tbl[1]  = '{1'b0, 1'b1, 1'b1, 6, 10'b00_0_0_0000_00, "walk_r_early"};
      tbl[2]  = '{1'b0, 1'b1, 1'b1, 1, 10'b01_0_0_0000_00, "walk_r"};
      tbl[3]  = '{1'b1, 1'b1, 1'b1, 3, 10'b01_0_0_0000_00, "glitch_on"};
      tbl[4]  = '{1'b0, 1'b1, 1'b1, 10, 10'b01_0_0_0000_00, "glitch_off"};
      tbl[5]  = '{1'b1, 1'b1, 1'b1, 6, 10'b01_0_0_0000_00, "both_early"};
      tbl[6]  = '{1'b1, 1'b1, 1'b1, 1, 10'b00_0_0_0000_00, "both"};
      tbl[7]  = '{1'b1, 1'b0, 1'b1, 7, 10'b10_0_0_0000_00, "left_only"};
      tbl[8]  = '{1'b1, 1'b0, 1'b0, 1, 10'b00_0_0_0000_00, "ground_low"};
      tbl[9]  = '{1'b1, 1'b0, 1'b1, 1, 10'b10_0_0_0000_00, "ground_back"};
      tbl[10] = '{1'b0, 1'b0, 1'b1, 7, 10'b00_0_0_0000_00, "release_left"};

      cyc(3);
      check("in_reset", 32'(obs), 32'd0);
      sys_rst_n = 1'b1;

      for (int i = 0; i < 11; i++) begin
         left_btn  = tbl[i].l;
         right_btn = tbl[i].r;
         on_ground = tbl[i].g;
         cyc(tbl[i].cyc);
         check(tbl[i].name, 32'(obs), 32'(tbl[i].exp));
      end

      // 200-cycle hold, then stay on ground until the launch times out
      jump_btn = 1'b1;
      cyc(6);
      check("charge_not_yet", 32'(charging), 32'd0);
      cyc(1);
      check("charge_on", 32'(charging), 32'd1);
      cyc(193);
      check("charge_held", 32'({move_dir, charging}), 32'b001);
      jump_btn = 1'b0;
      pulses = 0; req_at = -1; move_at = -1; pw = '0; dr = '0;
      for (int i = 1; i <= 60; i++) begin
         cyc(1);
         if (jump_req) begin
            pulses++;
            if (req_at < 0) begin
               req_at = i;
               pw = jump_power;
               dr = jump_dir;
            end
         end
         if (move_dir == 2'b01 && move_at < 0) move_at = i;
         if (i == 1) right_btn = 1'b1;
      end
      check("req_count_200", 32'(pulses), 32'd1);
      check("req_latency", 32'(req_at), 32'd7);
      check("power_200", 32'(pw), 32'd11);
      check("dir_200", 32'(dr), 32'd0);
      check("power_hold", 32'(jump_power), 32'd11);
      check("timeout_exit_window", 32'((move_at - req_at >= 36) && (move_at - req_at <= 46)), 32'd1);

      right_btn = 1'b0;
      cyc(8);

      // 1000-cycle hold with right pressed mid-charge: saturation and direction
      jump_btn = 1'b1;
      cyc(20);
      right_btn = 1'b1;
      bad = 0;
      for (int i = 0; i < 980; i++) begin
         cyc(1);
         if (move_dir != 2'b00) bad++;
      end
      check("move_zero_in_charge", 32'(bad), 32'd0);
      jump_btn = 1'b0;
      n = 0;
      while (!jump_req && n < 20) begin
         cyc(1);
         n++;
      end
      check("req_seen_sat", 32'(jump_req), 32'd1);
      check("power_sat", 32'(jump_power), 32'd15);
      check("dir_sat", 32'(jump_dir), 32'd1);
      cyc(1);
      check("req_one_cycle", 32'(jump_req), 32'd0);
      on_ground = 1'b0;
      cyc(3);
      check("air_move_zero", 32'(move_dir), 32'd0);
      on_ground = 1'b1;
      cyc(3);
      check("land_move", 32'(move_dir), 32'd1);
      check("land_power_hold", 32'(jump_power), 32'd15);
      right_btn = 1'b0;
      cyc(8);

      // ground lost mid-charge
      jump_btn = 1'b1;
      cyc(30);
      check("abort_charging", 32'(charging), 32'd1);
      on_ground = 1'b0;
      cyc(1);
      check("abort_state", 32'({charging, jump_power}), 32'd0);
      jump_btn = 1'b0;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(1);
         if (jump_req || charging) bad++;
      end
      check("abort_no_req", 32'(bad), 32'd0);
      on_ground = 1'b1;
      cyc(10);

      // press while airborne, keep holding after landing
      on_ground = 1'b0;
      jump_btn = 1'b1;
      cyc(10);
      on_ground = 1'b1;
      bad = 0;
      for (int i = 0; i < 30; i++) begin
         cyc(1);
         if (charging || jump_req) bad++;
      end
      check("air_press_ignored", 32'(bad), 32'd0);
      jump_btn = 1'b0;
      cyc(10);

      // reset pulse mid-charge
      jump_btn = 1'b1;
      cyc(30);
      check("rst_pre_charging", 32'(charging), 32'd1);
      sys_rst_n = 1'b0;
      jump_btn = 1'b0;
      cyc(1);
      check("rst_mid_outputs", 32'(obs), 32'd0);
      cyc(1);
      sys_rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 30; i++) begin
         cyc(1);
         if (charging || jump_req) bad++;
      end
      check("rst_no_req", 32'(bad), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
